// File: rtl/chan_mux_arb.sv
// N-channel to 1 word mux, addressed or round-robin select; optional CHAN_MUX_STATS_EN adds xfer_count.
// Latency: 1 cycle from input transfer to out_valid, full throughput via drain-and-reload.
// Backpressure: while out_valid & !out_ready the output holds and every in_ready bit is low.
module chan_mux_arb #(
    parameter int WIDTH    = 20,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          addr,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
`ifdef CHAN_MUX_STATS_EN
    ,
    output logic [15:0]               xfer_count
`endif
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_chan;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load;
    logic             w_addr_hit;
    logic             w_rr_vld;
    logic [SEL_W-1:0] w_rr_gnt;
    logic [SEL_W:0]   w_rr_idx;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_grant;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    assign w_load = !r_out_valid || out_ready;

    // Addresses at or beyond CHANNELS match no loop index, so they never grant.
    always_comb begin
        w_addr_hit = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (addr == SEL_W'(k)) begin
                w_addr_hit = in_valid[k];
            end
        end
    end

    // Search ptr, ptr+1, ... with wrap at CHANNELS; one extra index bit avoids overflow.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_gnt = '0;
        w_rr_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_rr_idx = {1'b0, r_ptr} + (SEL_W+1)'(i);
            if (w_rr_idx >= (SEL_W+1)'(CHANNELS)) begin
                w_rr_idx = w_rr_idx - (SEL_W+1)'(CHANNELS);
            end
            if (!w_rr_vld && in_valid[w_rr_idx[SEL_W-1:0]]) begin
                w_rr_vld = 1'b1;
                w_rr_gnt = w_rr_idx[SEL_W-1:0];
            end
        end
    end

    assign w_gnt_vld  = mode ? w_rr_vld : w_addr_hit;
    assign w_grant    = mode ? w_rr_gnt : addr;
    assign w_xfer     = w_load && w_gnt_vld && !rst;
    assign w_sel_data = in_data[int'(w_grant)*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_gnt_vld) begin
                r_out_data  <= w_sel_data;
                r_out_chan  <= w_grant;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_ptr <= (w_grant == SEL_W'(CHANNELS-1)) ? '0 : w_grant + 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;

`ifdef CHAN_MUX_STATS_EN
    logic [15:0] r_xfer_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (w_xfer && (r_xfer_count != 16'hFFFF)) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_chan_mux_arb.sv
// Randomised and directed bench for chan_mux_arb against a queue-free behavioural model.
module tb_chan_mux_arb;

    localparam int W = 20;
    localparam int C = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [C*W-1:0] in_data;
    logic [C-1:0]   in_valid;
    logic [C-1:0]   in_ready;
    logic           mode;
    logic [3:0]     addr;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [3:0]     out_chan;

    logic [11:0]    in_ready12;
    logic [W-1:0]   out_data12;
    logic           out_valid12;
    logic [3:0]     out_chan12;

`ifdef CHAN_MUX_STATS_EN
    logic [15:0]    xfer_count;
    logic [15:0]    xfer_count12;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: what the registered output and pointer should hold.
    logic           m_vld;
    logic [W-1:0]   m_data;
    int             m_chan;
    int             m_ptr;

    always #5 clk = ~clk;

    chan_mux_arb #(.WIDTH(W), .CHANNELS(C), .SEL_W(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .addr(addr), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
`ifdef CHAN_MUX_STATS_EN
        , .xfer_count(xfer_count)
`endif
    );

    chan_mux_arb #(.WIDTH(W), .CHANNELS(12), .SEL_W(4)) dut12 (
        .clk(clk), .rst(rst), .in_data(in_data[12*W-1:0]), .in_valid(in_valid[11:0]),
        .in_ready(in_ready12), .mode(mode), .addr(addr), .out_data(out_data12),
        .out_valid(out_valid12), .out_ready(out_ready), .out_chan(out_chan12)
`ifdef CHAN_MUX_STATS_EN
        , .xfer_count(xfer_count12)
`endif
    );

    function automatic int m_gnt();
        if (!mode) return in_valid[addr] ? int'(addr) : -1;
        for (int i = 0; i < C; i++) begin
            if (in_valid[(m_ptr + i) % C]) return (m_ptr + i) % C;
        end
        return -1;
    endfunction

    function automatic logic [C-1:0] m_ready();
        int g;
        logic [C-1:0] r;
        r = '0;
        g = m_gnt();
        if (!rst && (!m_vld || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic advance();
        int g;
        @(posedge clk);
        if (rst) begin
            m_vld = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
        end else if (!m_vld || out_ready) begin
            g = m_gnt();
            if (g >= 0) begin
                m_vld  = 1'b1;
                m_data = in_data[g*W +: W];
                m_chan = g;
                if (mode) m_ptr = (g + 1) % C;
            end else begin
                m_vld = 1'b0;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < C; k++) in_data[k*W +: W] = W'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; addr = 4'd0; in_valid = '1; out_ready = 1'b1;
        rand_data();
        m_vld = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 16'h0000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_valid: got ready=%h valid=%b want 0000/0", in_ready, out_valid);
        end
        n_cmp++;
        if (out_data !== 20'h0 || out_chan !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_data_chan: got data=%h chan=%0d want 0/0", out_data, out_chan);
        end
        advance();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 16'h0001) begin
            n_fail++;
            $display("FAIL reset_ptr_zero: got ready=%h want 0001", in_ready);
        end
    endtask

    task automatic test_addressed();
        mode = 1'b0; addr = 4'd5; in_valid = 16'h0020; out_ready = 1'b1;
        rand_data();
        in_data[5*W +: W] = 20'hABCDE;
        #1;
        n_cmp++;
        if (in_ready !== 16'h0020) begin
            n_fail++;
            $display("FAIL addr_ready: got %h want 0020", in_ready);
        end
        advance();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 20'hABCDE || out_chan !== 4'd5) begin
            n_fail++;
            $display("FAIL addr_out: got v=%b d=%h c=%0d want 1/abcde/5", out_valid, out_data, out_chan);
        end
    endtask

    task automatic test_rr_fairness();
        rst = 1'b1;
        advance();
        rst = 1'b0; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== (16'h0001 << (i % C)) || $countones(in_ready) != 1) begin
                n_fail++;
                $display("FAIL rr_ready[%0d]: got %h want %h", i, in_ready, 16'h0001 << (i % C));
            end
            advance();
            n_cmp++;
            if (out_chan !== 4'(i % C) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_chan[%0d]: got %0d want %0d", i, out_chan, i % C);
            end
        end
    endtask

    task automatic test_skip_wrap();
        logic [C-1:0] exp_seq [3];
        exp_seq[0] = 16'h0001; exp_seq[1] = 16'h0008; exp_seq[2] = 16'h0001;
        mode = 1'b1; out_ready = 1'b1; in_valid = 16'h2000;
        #1;
        n_cmp++;
        if (in_ready !== 16'h2000) begin
            n_fail++;
            $display("FAIL skip_ch13: got %h want 2000", in_ready);
        end
        advance();
        in_valid = 16'h0009;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== exp_seq[i] || in_ready !== m_ready()) begin
                n_fail++;
                $display("FAIL skip_wrap[%0d]: got %h want %h", i, in_ready, exp_seq[i]);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        logic [3:0]   c;
        logic [3:0]   nc;
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        rand_data();
        advance();
        out_ready = 1'b0;
        d = out_data; c = out_chan;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_valid: got %b want 1", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 16'h0 || out_data !== d || out_chan !== c || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got r=%h d=%h c=%0d want 0000/%h/%0d", i, in_ready, out_data, out_chan, d, c);
            end
            advance();
        end
        out_ready = 1'b1;
        nc = c + 4'd1;
        #1;
        n_cmp++;
        if (in_ready !== (16'h0001 << nc)) begin
            n_fail++;
            $display("FAIL bp_reload_ready: got %h want %h", in_ready, 16'h0001 << nc);
        end
        advance();
        n_cmp++;
        if (out_valid !== 1'b1 || out_chan !== nc || out_data !== in_data[int'(nc)*W +: W]) begin
            n_fail++;
            $display("FAIL bp_reload: got v=%b c=%0d d=%h want 1/%0d/%h", out_valid, out_chan, out_data, nc, in_data[int'(nc)*W +: W]);
        end
    endtask

    task automatic test_invalid_empty();
        mode = 1'b0; addr = 4'd11; in_valid = '1; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready12 !== 12'h800) begin
            n_fail++;
            $display("FAIL addr11_ready12: got %h want 800", in_ready12);
        end
        advance();
        addr = 4'd13;
        #1;
        n_cmp++;
        if (in_ready12 !== 12'h000 || out_valid12 !== 1'b1) begin
            n_fail++;
            $display("FAIL addr13_ready12: got r=%h v=%b want 000/1", in_ready12, out_valid12);
        end
        advance();
        n_cmp++;
        if (out_valid12 !== 1'b0) begin
            n_fail++;
            $display("FAIL addr13_drop: got %b want 0", out_valid12);
        end
        mode = 1'b1; in_valid = '0;
        advance();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 16'h0) begin
            n_fail++;
            $display("FAIL empty: got v=%b r=%h want 0/0000", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        advance();
        advance();
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 16'h0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got r=%h v=%b want 0000/1", in_ready, out_valid);
        end
        advance();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 16'h0001) begin
            n_fail++;
            $display("FAIL rstmid_post: got v=%b r=%h want 0/0001", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            mode      = 1'($urandom);
            addr      = 4'($urandom);
            in_valid  = 16'($urandom) & 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            #1;
            n_cmp++;
            if (in_ready !== m_ready()) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %h want %h", i, in_ready, m_ready());
            end
            advance();
            n_cmp++;
            if (out_valid !== m_vld || out_data !== m_data || out_chan !== 4'(m_chan)) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h c=%0d want %b/%h/%0d", i, out_valid, out_data, out_chan, m_vld, m_data, m_chan);
            end
        end
        rst = 1'b0;
    endtask

`ifdef CHAN_MUX_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        advance();
        rst = 1'b0; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) advance();
        n_cmp++;
        if (xfer_count !== 16'd100) begin
            n_fail++;
            $display("FAIL stats_100: got %0d want 100", xfer_count);
        end
        for (int i = 100; i < 70000; i++) advance();
        n_cmp++;
        if (xfer_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stats_sat: got %h want ffff", xfer_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_addressed();
        test_rr_fairness();
        test_skip_wrap();
        test_backpressure();
        test_invalid_empty();
        test_reset_mid();
        test_random();
`ifdef CHAN_MUX_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_mux_arb.md
Name: chan_mux_arb

Overview:
- Parametrised N-channel to 1 word multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Generalises the fixed 16x20 combinational mux tree. Supports two modes:
  - addressed select: the caller picks the channel.
  - round-robin arbitration: the block picks the next requesting channel.
- Sits between multiple producers (register-file read ports, I/O sources) and a single consumer in the datapath.

Parameters:
- WIDTH, 20, data word width in bits.
- CHANNELS, 16, number of input channels; legal range 2..256.
- SEL_W, 4, channel index width; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  packed channel words; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel request.
- in_ready  output  CHANNELS  per-channel accept; at most one bit high per cycle.
- mode  input  1  0 = addressed select, 1 = round-robin.
- addr  input  SEL_W  channel index, used only when mode = 0.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accept.
- out_chan  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high. Clock and reset ports are named clk and rst.
- Reset values: out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0. in_ready is combinational and is therefore 0 during reset.
- Load enable: load = !out_valid | out_ready. A new word can load in the same cycle the old word drains, giving full throughput of one word per cycle.
- Grant, mode 0:
  - g = addr if addr < CHANNELS and in_valid[addr].
  - Otherwise no grant.
  - Any addr >= CHANNELS never grants.
- Grant, mode 1:
  - g = first k with in_valid[k] set, searching ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1 (wrap-around).
  - No grant if in_valid = 0.
- in_ready[g] = load & grant_exists. All other in_ready bits are 0. A transfer on channel g occurs when in_valid[g] & in_ready[g].
- On a transfer, at the clock edge:
  - out_data <= in_data[g].
  - out_chan <= g.
  - out_valid <= 1.
  - If mode = 1: ptr <= (g+1) mod CHANNELS, wrapping at CHANNELS, not at 2^SEL_W.
- If load is set and there is no grant: out_valid <= 0.
- If load is clear: all output registers hold.
- Latency: exactly 1 cycle from in-side transfer to out_valid.
- Backpressure: while out_valid & !out_ready, out_data and out_chan are stable and in_ready is all-zero.
- ptr updates only on mode-1 transfers. Mode-0 transfers and mode switches leave ptr untouched. A mode change takes effect at the next grant decision, with no flush.
- Reset mid-operation: the pending output word is discarded (out_valid -> 0) and ptr -> 0.

Optional Feature:
- Macro: CHAN_MUX_STATS_EN.
- With the macro defined:
  - Adds output port xfer_count, 16 bits.
  - Increments by 1 on every in-side transfer.
  - Saturates at 16'hFFFF.
  - Resets to 0.
- Without the macro: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Addressed pass-through: mode=0, addr=5, in_valid=16'h0020, in_data ch5=20'hABCDE, out_ready=1 -> in_ready=16'h0020; next cycle out_valid=1, out_data=20'hABCDE, out_chan=5.
- Round-robin fairness: mode=1, in_valid=16'hFFFF held, out_ready=1, 20 cycles after reset -> out_chan sequence 0,1,...,15,0,1,2,3; exactly one in_ready bit per cycle.
- Round-robin skip and wrap: ptr=14 after a grant on ch13, in_valid=16'h0009 -> grants ch0, then ch3, then ch0.
- Backpressure: out_ready=0 with out_valid=1 for 4 cycles while all channels request -> out_data/out_chan unchanged, in_ready=0; out_ready=1 -> one drain and one reload in the same cycle.
- Invalid address and empty: CHANNELS=12, mode=0, addr=13 -> no grant, out_valid drops after drain. Also in_valid=0 -> out_valid=0.
- Reset and stats: rst asserted mid-stream with out_valid=1 -> next cycle out_valid=0, ptr=0. With CHAN_MUX_STATS_EN, 70000 transfers -> xfer_count=16'hFFFF.
